// File: rtl/parity_frame_checker.sv
// Multi-channel serial parity frame checker: FRAME_BITS data bits followed by one parity bit per frame.
// Define PARITY_FRAME_ERRCNT_EN to build the saturating failed-frame counter; otherwise err_count is tied to 0.
module parity_frame_checker #(
  parameter int FRAME_BITS = 8,
  parameter int CHANNELS   = 1,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [CHANNELS-1:0] in_bit,
  input  logic                odd_mode,
  output logic [CHANNELS-1:0] running_par,
  output logic [CHANNELS-1:0] frame_done,
  output logic [CHANNELS-1:0] parity_ok,
  output logic [CNT_W-1:0]    err_count
);

  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS);

  typedef enum logic {
    DATA = 1'b0,
    PAR  = 1'b1
  } state_t;

`ifdef PARITY_FRAME_ERRCNT_EN
  logic [CHANNELS-1:0] bad_frame;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_t         state_q, state_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic           acc_q, acc_d;
    logic           ok_q, ok_d;
    logic           done_q, done_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= DATA;
        cnt_q   <= '0;
        acc_q   <= 1'b0;
        ok_q    <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        ok_q    <= ok_d;
        done_q  <= done_d;
      end
    end

    // odd_mode is only looked at when the parity bit arrives, so mid-frame changes are harmless
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ok_d    = ok_q;
      done_d  = 1'b0;
      if (in_valid[g]) begin
        case (state_q)
          DATA: begin
            acc_d = acc_q ^ in_bit[g];
            cnt_d = cnt_q + BCW'(1);
            if (cnt_d == LAST_BIT) state_d = PAR;
          end
          PAR: begin
            ok_d    = ((acc_q ^ in_bit[g]) == odd_mode);
            done_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = 1'b0;
            state_d = DATA;
          end
          default: state_d = DATA;
        endcase
      end
    end

    assign running_par[g] = acc_q;
    assign frame_done[g]  = done_q;
    assign parity_ok[g]   = ok_q;
`ifdef PARITY_FRAME_ERRCNT_EN
    assign bad_frame[g]   = done_d & ~ok_d;
`endif
  end

`ifdef PARITY_FRAME_ERRCNT_EN
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] ERR_MAX = {4'b0000, {CNT_W{1'b1}}};

  logic [3:0]       bad_num;
  logic [SUM_W-1:0] err_sum;
  logic [CNT_W-1:0] err_q;

  // Failing frames are counted on the same edge that publishes their parity_ok
  always_comb begin
    bad_num = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bad_num = bad_num + {3'b000, bad_frame[i]};
    end
    err_sum = {4'b0000, err_q} + {{CNT_W{1'b0}}, bad_num};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (err_sum > ERR_MAX) begin
      err_q <= '1;
    end else begin
      err_q <= err_sum[CNT_W-1:0];
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker: a 4-channel 8-bit instance plus a 1-bit-frame instance.
module tb_parity_frame_checker;

  localparam int FB = 8;
  localparam int CH = 4;
  localparam int CW = 8;
`ifdef PARITY_FRAME_ERRCNT_EN
  localparam int ERR_LIM = 255;
`else
  localparam int ERR_LIM = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] in_valid, in_bit;
  logic          odd_mode;
  logic [CH-1:0] running_par, frame_done, parity_ok;
  logic [CW-1:0] err_count;

  logic          v1, b1, om1;
  logic          rp1, fd1, ok1;
  logic [CW-1:0] ec1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_err = 0;
  int exp_err1 = 0;

  parity_frame_checker #(.FRAME_BITS(FB), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .odd_mode(odd_mode),
    .running_par(running_par), .frame_done(frame_done), .parity_ok(parity_ok), .err_count(err_count)
  );

  parity_frame_checker #(.FRAME_BITS(1), .CHANNELS(1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_bit(b1), .odd_mode(om1),
    .running_par(rp1), .frame_done(fd1), .parity_ok(ok1), .err_count(ec1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic b;
    logic om;
    logic done;
    logic ok;
    logic rp;
  } vec_t;

  vec_t tbl [12];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add_err(input int n);
    exp_err = (exp_err + n > ERR_LIM) ? ERR_LIM : exp_err + n;
  endtask

  // Leaves in_valid asserted after the parity bit so a following call runs back-to-back
  task automatic apply_stimulus(input logic [CH-1:0] mask, input logic [7:0] data,
                                input logic [CH-1:0] par, input int gap);
    logic rp;
    rp = 1'b0;
    for (int i = 0; i < FB; i++) begin
      in_valid = mask;
      in_bit   = data[FB-1-i] ? mask : '0;
      rp       = rp ^ data[FB-1-i];
      step();
      check_output("data_done", frame_done, 0);
      check_output("data_rp", running_par & mask, rp ? mask : '0);
      for (int j = 0; j < gap; j++) begin
        in_valid = '0;
        in_bit   = '1;
        step();
        check_output("gap_done", frame_done, 0);
        check_output("gap_rp", running_par & mask, rp ? mask : '0);
      end
    end
    in_valid = mask;
    in_bit   = par & mask;
    step();
  endtask

  task automatic check_frame(input string name, input logic [CH-1:0] mask, input logic [CH-1:0] ok);
    check_output({name, "_done"}, frame_done, mask);
    check_output({name, "_ok"}, parity_ok & mask, ok & mask);
    check_output({name, "_rp"}, running_par & mask, 0);
    check_output({name, "_err"}, err_count, exp_err);
  endtask

  initial begin
    int t0;
    reset    = 1'b1;
    in_valid = '0;
    in_bit   = '0;
    odd_mode = 1'b0;
    v1 = 1'b0; b1 = 1'b0; om1 = 1'b0;
    tbl = '{
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}
    };
    step();
    step();
    reset = 1'b0;
    check_output("rst_rp", running_par, 0);
    check_output("rst_done", frame_done, 0);
    check_output("rst_ok", parity_ok, 0);
    check_output("rst_err", err_count, 0);
    check_output("rst1_rp", rp1, 0);
    check_output("rst1_done", fd1, 0);
    check_output("rst1_ok", ok1, 0);
    check_output("rst1_err", ec1, 0);

    // One-bit frames: every second valid bit is the parity bit
    for (int i = 0; i < 12; i++) begin
      v1  = tbl[i].v;
      b1  = tbl[i].b;
      om1 = tbl[i].om;
      step();
      if (tbl[i].done && !tbl[i].ok) exp_err1 = (exp_err1 + 1 > ERR_LIM) ? ERR_LIM : exp_err1 + 1;
      check_output("fb1_done", fd1, tbl[i].done);
      check_output("fb1_ok", ok1, tbl[i].ok);
      check_output("fb1_rp", rp1, tbl[i].rp);
      check_output("fb1_err", ec1, exp_err1);
    end
    v1 = 1'b0;

    apply_stimulus(4'b0001, 8'hB0, 4'b0001, 0);
    check_frame("even_good", 4'b0001, 4'b0001);
    in_valid = '0;
    step();
    check_output("pulse_end", frame_done, 0);
    check_output("ok_held", parity_ok[0], 1);

    apply_stimulus(4'b0001, 8'hB0, 4'b0000, 0);
    add_err(1);
    check_frame("even_bad", 4'b0001, 4'b0000);
    odd_mode = 1'b1;
    apply_stimulus(4'b0001, 8'hB0, 4'b0000, 0);
    check_frame("odd_good", 4'b0001, 4'b0001);
    odd_mode = 1'b0;

    in_valid = '0;
    step();
    apply_stimulus(4'b0001, 8'hB0, 4'b0001, 3);
    check_frame("gapped", 4'b0001, 4'b0001);

    // Reset in the middle of a frame, with in_valid still asserted
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'b0001;
      in_bit   = {3'b000, (i != 1 && i != 4)};
      step();
    end
    reset    = 1'b1;
    in_bit   = 4'b0001;
    step();
    reset    = 1'b0;
    in_valid = '0;
    exp_err  = 0;
    check_output("abort_done", frame_done, 0);
    check_output("abort_rp", running_par, 0);
    check_output("abort_ok", parity_ok, 0);
    check_output("abort_err", err_count, 0);
    step();
    check_output("abort_idle_done", frame_done, 0);
    apply_stimulus(4'b0001, 8'hB0, 4'b0001, 0);
    check_frame("after_abort", 4'b0001, 4'b0001);

    apply_stimulus(4'b0001, 8'hA5, 4'b0000, 0);
    t0 = cyc;
    check_frame("b2b_first", 4'b0001, 4'b0001);
    check_output("ch1_idle_a", {running_par[1], frame_done[1], parity_ok[1]}, 0);
    apply_stimulus(4'b0001, 8'h01, 4'b0001, 0);
    check_output("b2b_spacing", cyc - t0, FB + 1);
    check_frame("b2b_second", 4'b0001, 4'b0001);
    check_output("ch1_idle_b", {running_par[1], frame_done[1], parity_ok[1]}, 0);
    in_valid = '0;
    step();

    // Drive the error counter to 253, then past saturation with four simultaneous bad frames
    for (int r = 0; r < 63; r++) begin
      apply_stimulus(4'b1111, 8'h00, 4'b1111, 0);
      add_err(4);
      check_output("bulk_done", frame_done, 4'b1111);
      check_output("bulk_err", err_count, exp_err);
    end
    apply_stimulus(4'b0001, 8'h00, 4'b0001, 0);
    add_err(1);
    check_frame("err_253", 4'b0001, 4'b0000);
    apply_stimulus(4'b1111, 8'h00, 4'b1111, 0);
    add_err(4);
    check_frame("err_sat", 4'b1111, 4'b0000);
    apply_stimulus(4'b1111, 8'h00, 4'b1111, 0);
    add_err(4);
    check_frame("err_sat_hold", 4'b1111, 4'b0000);
    in_valid = '0;
    step();
    check_output("final_done", frame_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 The module SHALL have parameter FRAME_BITS, default 8, giving the number of data bits per frame (legal 1..32).
REQ-002 The module SHALL have parameter CHANNELS, default 1, giving the number of independent serial channels (legal 1..8).
REQ-003 The module SHALL have parameter CNT_W, default 8, giving the width of the error counter (legal 2..16).
REQ-004 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, CHANNELS bits: per-channel bit-valid qualifier.
REQ-007 Port in_bit, input, CHANNELS bits: per-channel serial data; sampled only when the matching in_valid is 1.
REQ-008 Port odd_mode, input, 1 bit: 0 selects even parity and 1 selects odd parity, shared by all channels.
REQ-009 Port running_par, output, CHANNELS bits: registered XOR of the data bits accepted so far in the current frame.
REQ-010 Port frame_done, output, CHANNELS bits: one-cycle pulse marking a completed frame.
REQ-011 Port parity_ok, output, CHANNELS bits: result of the last completed frame, held until the next frame_done.
REQ-012 Port err_count, output, CNT_W bits: saturating count of failed frames across all channels.

Function
REQ-013 Each channel SHALL keep a bit counter (0..FRAME_BITS) and a parity accumulator; channels SHALL be fully independent except for err_count.
REQ-014 The per-channel FSM SHALL have two states: DATA (counter < FRAME_BITS) and PAR (counter == FRAME_BITS).
REQ-015 DATA state, in_valid=1: accumulator <= accumulator ^ in_bit; counter increments; the channel moves to PAR when the counter reaches FRAME_BITS.
REQ-016 PAR state, in_valid=1: in_bit is the parity bit; parity_ok <= ((accumulator ^ in_bit) == odd_mode); frame_done pulses; counter and accumulator clear to 0; the channel returns to DATA.
REQ-017 frame_done and parity_ok SHALL update on the clock edge that samples the parity bit, so they are visible 1 cycle after that bit is presented.
REQ-018 in_valid=0 in either state SHALL hold the channel's counter, accumulator, parity_ok and running_par, and frame_done SHALL be 0.
REQ-019 odd_mode SHALL be evaluated only in the cycle the parity bit is sampled; changes mid-frame SHALL NOT affect accumulated data.
REQ-020 running_par SHALL equal the accumulator register, returning to 0 on the edge that closes a frame.
REQ-021 Back-to-back frames (parity bit, then the next data bit in the following cycle) SHALL be accepted with no idle cycle.
REQ-022 For FRAME_BITS=1, each frame SHALL be exactly 2 valid bits.

Reset
REQ-023 When reset=1 at a clock edge, every counter, accumulator, running_par, frame_done, parity_ok and err_count SHALL become 0, and every channel SHALL enter DATA.
REQ-024 Reset SHALL take priority over in_valid; a partial frame interrupted by reset SHALL be discarded, with no frame_done and no error counted.

Configuration
REQ-025 Macro PARITY_FRAME_ERRCNT_EN SHALL control the error counter.
REQ-026 With the macro defined, on every edge err_count SHALL add the number of channels whose frame completes with parity_ok=0 in that cycle, saturating at 2^CNT_W-1.
REQ-027 Without the macro, the err_count port SHALL remain present, be tied to 0, and no counter logic SHALL be synthesised.

Verification
REQ-028 FRAME_BITS=8, CHANNELS=1, odd_mode=0, send 8'b1011_0000 then parity 1 -> frame_done pulse 1 cycle later, parity_ok=1, err_count=0.
REQ-029 Same data with parity 0, macro defined -> parity_ok=0, err_count=1; repeat with odd_mode=1 -> parity_ok=1, err_count unchanged.
REQ-030 CHANNELS=4, all four complete bad frames in the same cycle with err_count=2^CNT_W-3 (CNT_W=8, value 253) -> err_count=255 (saturated), and stays 255 on further errors.
REQ-031 Insert in_valid=0 gaps of 3 cycles between data bits -> same result as the gap-free frame; frame_done=0 during the gaps; running_par steps only on valid bits.
REQ-032 Assert reset after 5 data bits, then send a full good frame -> no frame_done for the aborted frame; the next frame gives parity_ok=1 with err_count=0.
REQ-033 Send two frames back-to-back on channel 0 while channel 1 is idle -> two frame_done pulses on channel 0 exactly FRAME_BITS+1 cycles apart; channel 1 outputs stay 0.
